// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and sizing helpers for the line buffer controller.
package lb_pkg;

    typedef enum logic {
        LB_PRIME,
        LB_STREAM
    } lb_state_e;

    localparam int LB_IMG_W_DEF = 640;
    localparam int LB_IMG_H_DEF = 480;

    function automatic int lb_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LB_XW_DEF = lb_cw(LB_IMG_W_DEF);
    localparam int LB_YW_DEF = lb_cw(LB_IMG_H_DEF);

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel-in / column-out bundle of the line buffer controller.
interface line_buffer_ctrl_if
    import lb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMG_W = LB_IMG_W_DEF,
    parameter int IMG_H = LB_IMG_H_DEF
) ();
    localparam int XW = lb_cw(IMG_W);
    localparam int YW = lb_cw(IMG_H);

    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [WIDTH-1:0] in_pixel;
    logic             out_valid;
    logic [WIDTH-1:0] out_top;
    logic [WIDTH-1:0] out_mid;
    logic [WIDTH-1:0] out_bot;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;
    logic             out_eol;
    logic             out_eof;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  in_ready,
        input  out_valid, out_top, out_mid, out_bot,
        input  out_x, out_y, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output in_ready,
        output out_valid, out_top, out_mid, out_bot,
        output out_x, out_y, out_eol, out_eof
    );
endinterface

// File: rtl/line_buffer_ctrl_pos_counter.sv
// Raster x/y tracking; sof forces the current pixel to (0,0).
module lb_pos_counter
    import lb_pkg::*;
#(
    parameter int IMG_W = LB_IMG_W_DEF,
    parameter int IMG_H = LB_IMG_H_DEF,
    parameter int XW    = lb_cw(IMG_W),
    parameter int YW    = lb_cw(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_acc,
    input  logic          i_sof,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_eol,
    output logic          o_eof,
    output logic          o_row1
);
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_last_row;

    assign o_x        = i_sof ? '0 : r_x;
    assign o_y        = i_sof ? '0 : r_y;
    assign o_eol      = (o_x == XW'(IMG_W - 1));
    assign w_last_row = (o_y == YW'(IMG_H - 1));
    assign o_eof      = o_eol & w_last_row;
    assign o_row1     = (o_y == YW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_acc) begin
            if (o_eol) begin
                r_x <= '0;
                r_y <= w_last_row ? '0 : o_y + YW'(1);
            end else begin
                r_x <= o_x + XW'(1);
                r_y <= o_y;
            end
        end
    end
endmodule

// File: rtl/simple_dual_port_ram.sv
// One write port, one registered read port; contents are never reset.
module simple_dual_port_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 640,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/line_buffer_ctrl.sv
// Two-line buffer emitting (y-2, y-1, y) columns per accepted pixel.
// LB_ZERO_PAD_EN: emit rows 0..1 too, with missing rows padded as zero.
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMG_W = LB_IMG_W_DEF,
    parameter int IMG_H = LB_IMG_H_DEF
) (
    input logic               clk,
    input logic               rst,
    line_buffer_ctrl_if.slave bus
);
    localparam int XW = lb_cw(IMG_W);
    localparam int YW = lb_cw(IMG_H);

    logic             w_acc, w_emit;
    logic [XW-1:0]    w_x;
    logic [YW-1:0]    w_y;
    logic             w_eol, w_eof, w_row1;
    lb_state_e        r_state, w_state_nx;
    logic             r_d1_vld, r_d1_emit;
    logic [WIDTH-1:0] r_d1_pix;
    logic [XW-1:0]    r_d1_x;
    logic [YW-1:0]    r_d1_y;
    logic             r_d1_eol, r_d1_eof;
    logic [WIDTH-1:0] w_row1_q, w_row2_q, w_top, w_mid;
    logic [WIDTH-1:0] r_o_top, r_o_mid, r_o_bot;
    logic [XW-1:0]    r_o_x;
    logic [YW-1:0]    r_o_y;
    logic             r_o_eol, r_o_eof;

    assign bus.in_ready = !rst;
    assign w_acc        = bus.in_valid & !rst;

    lb_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
        .clk    (clk),
        .rst    (rst),
        .i_acc  (w_acc),
        .i_sof  (bus.in_sof),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_eol  (w_eol),
        .o_eof  (w_eof),
        .o_row1 (w_row1)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= LB_PRIME;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_acc) begin
            if (bus.in_sof || w_eof)
                w_state_nx = LB_PRIME;
            else if (r_state == LB_PRIME && w_eol && w_row1)
                w_state_nx = LB_STREAM;
        end
`ifdef LB_ZERO_PAD_EN
        w_emit = 1'b1;
`else
        w_emit = (r_state == LB_STREAM) && !bus.in_sof;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1_vld  <= 1'b0;
            r_d1_emit <= 1'b0;
        end else begin
            r_d1_vld  <= w_acc;
            r_d1_emit <= w_acc & w_emit;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_d1_pix <= bus.in_pixel;
            r_d1_x   <= w_x;
            r_d1_y   <= w_y;
            r_d1_eol <= w_eol;
            r_d1_eof <= w_eof;
        end
    end

    // row1 feeds row2 so the two memories cascade one row apart
    simple_dual_port_ram #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_row1 (
        .clk     (clk),
        .i_we    (r_d1_vld),
        .i_waddr (r_d1_x),
        .i_wdata (r_d1_pix),
        .i_re    (w_acc),
        .i_raddr (w_x),
        .o_rdata (w_row1_q)
    );

    simple_dual_port_ram #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_row2 (
        .clk     (clk),
        .i_we    (r_d1_vld),
        .i_waddr (r_d1_x),
        .i_wdata (w_row1_q),
        .i_re    (w_acc),
        .i_raddr (w_x),
        .o_rdata (w_row2_q)
    );

    always_comb begin
        w_top = w_row2_q;
        w_mid = w_row1_q;
`ifdef LB_ZERO_PAD_EN
        if (r_d1_y < YW'(2)) w_top = '0;
        if (r_d1_y == '0)    w_mid = '0;
`endif
    end

    // Hold copies keep the outputs stable between columns
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_top <= '0;
            r_o_mid <= '0;
            r_o_bot <= '0;
            r_o_x   <= '0;
            r_o_y   <= '0;
            r_o_eol <= 1'b0;
            r_o_eof <= 1'b0;
        end else if (r_d1_emit) begin
            r_o_top <= w_top;
            r_o_mid <= w_mid;
            r_o_bot <= r_d1_pix;
            r_o_x   <= r_d1_x;
            r_o_y   <= r_d1_y;
            r_o_eol <= r_d1_eol;
            r_o_eof <= r_d1_eof;
        end
    end

    assign bus.out_valid = r_d1_emit;
    assign bus.out_top   = r_d1_emit ? w_top    : r_o_top;
    assign bus.out_mid   = r_d1_emit ? w_mid    : r_o_mid;
    assign bus.out_bot   = r_d1_emit ? r_d1_pix : r_o_bot;
    assign bus.out_x     = r_d1_emit ? r_d1_x   : r_o_x;
    assign bus.out_y     = r_d1_emit ? r_d1_y   : r_o_y;
    assign bus.out_eol   = r_d1_emit ? r_d1_eol : r_o_eol;
    assign bus.out_eof   = r_d1_emit ? r_d1_eof : r_o_eof;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a 4x4 frame, pixel = base+16*y+x.
module tb_line_buffer_ctrl;
    import lb_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WD = 16;
`ifdef LB_ZERO_PAD_EN
    localparam int NCOL = 16;
`else
    localparam int NCOL = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntot = 0;
    int   npass = 0;
    int   nfail = 0;
    int   ncol = 0;
    int   n0;

    line_buffer_ctrl_if #(.WIDTH(WD), .IMG_W(W), .IMG_H(H)) bus ();

    line_buffer_ctrl #(.WIDTH(WD), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.out_valid === 1'b1) ncol++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_col();
        return {9'b0, bus.out_valid, bus.out_top, bus.out_mid, bus.out_bot,
                bus.out_x, bus.out_y, bus.out_eol, bus.out_eof};
    endfunction

    function automatic logic [63:0] exp_col(int x, int y, int base);
        logic [15:0] t, m, b;
        logic [1:0]  ex, ey;
        b  = 16'(base + 16 * y + x);
        m  = 16'(base + 16 * (y - 1) + x);
        t  = 16'(base + 16 * (y - 2) + x);
        ex = 2'(x);
        ey = 2'(y);
`ifdef LB_ZERO_PAD_EN
        if (y < 2)  t = '0;
        if (y == 0) m = '0;
`endif
        return {9'b0, 1'b1, t, m, b, ex, ey,
                1'(x == W - 1), 1'(x == W - 1 && y == H - 1)};
    endfunction

    function automatic bit emits(int y);
`ifdef LB_ZERO_PAD_EN
        return 1'b1;
`else
        return y >= 2;
`endif
    endfunction

    task automatic send(int x, int y, int base, bit sof);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = 16'(base + 16 * y + x);
        @(posedge clk);
        #1;
        if (emits(y))
            chk($sformatf("col(%0d,%0d)b%0h", x, y, base), obs_col(),
                exp_col(x, y, base));
        else
            chk($sformatf("quiet(%0d,%0d)", x, y), {63'b0, bus.out_valid},
                64'd0);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        @(posedge clk);
        #1;
        chk("gap_valid", {63'b0, bus.out_valid}, 64'd0);
    endtask

    task automatic run(int base, int start, int n, bit use_sof, bit gaps);
        for (int i = start; i < start + n; i++) begin
            send(i % W, i / W, base, use_sof && i == 0);
            if (gaps) idle();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("rst_outs", obs_col(), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_pixel = 16'hdead;
        @(posedge clk);
        #1;
        chk("rst_drop", obs_col(), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("ready", {63'b0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        n0 = ncol;
        run(0, 0, 16, 1'b1, 1'b0);
        idle();
        chk("ncol_frame", 64'(ncol - n0), 64'(NCOL));
        chk("hold", {47'b0, bus.out_valid, bus.out_bot, bus.out_eof},
            {47'b0, 1'b0, 16'h0033, 1'b1});

        n0 = ncol;
        run(0, 0, 16, 1'b1, 1'b1);
        chk("ncol_gaps", 64'(ncol - n0), 64'(NCOL));

        n0 = ncol;
        run(0, 0, 16, 1'b1, 1'b0);
        run(8'h80, 0, 16, 1'b0, 1'b0);
        idle();
        chk("ncol_b2b", 64'(ncol - n0), 64'(2 * NCOL));

        run(8'h40, 0, 10, 1'b1, 1'b0);
        run(8'h50, 0, 16, 1'b1, 1'b0);
        idle();

        run(8'h60, 0, 3, 1'b1, 1'b0);
        send(0, 0, 8'h70, 1'b1);
        run(8'h70, 1, 15, 1'b0, 1'b0);
        idle();

        run(8'h20, 0, 14, 1'b1, 1'b0);
        rst = 1'b1;
        bus.in_pixel = 16'hbeef;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", {63'b0, bus.in_ready}, 64'd0);
        chk("mid_rst_outs", obs_col(), 64'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n0 = ncol;
        run(0, 0, 16, 1'b0, 1'b0);
        idle();
        chk("ncol_post_rst", 64'(ncol - n0), 64'(NCOL));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
